// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, transmitter state encoding and the
// divider / frame-length helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Total frame length in system clock cycles.
    function automatic int calc_frame_len(input int data_bits, input int parity_mode,
                                          input int stop_bits, input int bps_cnt);
        return (1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits) * bps_cnt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; power-of-two depth so
// the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    // A write into a full FIFO is dropped even if a read frees a slot on the same edge.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed from a FIFO; frames leave back-to-back
// while words are queued, with optional parity and one or two stop bits.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int UART_BPS    = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_txd
);

    localparam int   BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int   CNT_W   = (BPS_CNT >= 2) ? $clog2(BPS_CNT) : 1;
    localparam int   IDX_W   = 4;
    localparam logic PAR_INV = (PARITY_MODE == PAR_ODD);

    if (BPS_CNT < 2) begin : g_bad_bps
        $error("uart_tx_fifo_param: CLK_FREQ/UART_BPS must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
    end
    if ((PARITY_MODE < PAR_NONE) || (PARITY_MODE > PAR_EVEN)) begin : g_bad_parity
        $error("uart_tx_fifo_param: PARITY_MODE must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two and >= 2");
    end

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   txd_q, txd_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   baud_end;
    logic                   frame_end;

    // A word transfers on each edge where tx_valid && tx_ready; tx_ready is
    // simply !full and never depends on tx_valid.
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_end  = (baud_cnt_q == BAUD_LAST);
    assign frame_end = (state_q == ST_STOP) && baud_end && (bit_idx_q == STOP_LAST);
    // Popping at frame end launches the next start bit with no idle gap.
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end && (bit_idx_q == DATA_LAST)) begin
                    state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (frame_end) begin
                    state_d = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit datapath: the shift register presents the next data bit in bit 0.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_end ? '0 : baud_cnt_q + CNT_W'(1);
        end
        if (fifo_pop) begin
            shift_d    = fifo_head;
            parity_d   = (^fifo_head) ^ PAR_INV;
            txd_d      = 1'b0;
            bit_idx_d  = '0;
            baud_cnt_d = '0;
        end else if (baud_end) begin
            case (state_q)
                ST_START: begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end
                ST_DATA: begin
                    if (bit_idx_q == DATA_LAST) begin
                        txd_d     = (PARITY_MODE != PAR_NONE) ? parity_q : 1'b1;
                        bit_idx_d = '0;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    txd_d     = 1'b1;
                    bit_idx_d = '0;
                end
                ST_STOP: begin
                    txd_d     = 1'b1;
                    bit_idx_d = (bit_idx_q == STOP_LAST) ? '0 : bit_idx_q + IDX_W'(1);
                end
                default: begin
                    txd_d = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        tx_ready = !fifo_full;
        tx_busy  = (state_q != ST_IDLE);
        tx_done  = frame_end;
        uart_txd = txd_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four instances (8N1, 8E1, 8O1, 7N2) at
// 10 clocks per bit; a line decoder checks every frame against a word queue.
module tb_uart_tx_fifo_param;

    localparam int BPS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid;
    logic [3:0] ready_w, busy_w, done_w, txd_w;
    logic [7:0] data0, data1, data2;
    logic [6:0] data3;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
                         .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(valid[0]), .tx_data(data0),
        .tx_ready(ready_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]),
        .fifo_level(lvl0), .uart_txd(txd_w[0]));

    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
                         .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(valid[1]), .tx_data(data1),
        .tx_ready(ready_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]),
        .fifo_level(lvl1), .uart_txd(txd_w[1]));

    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
                         .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(valid[2]), .tx_data(data2),
        .tx_ready(ready_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]),
        .fifo_level(lvl2), .uart_txd(txd_w[2]));

    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7),
                         .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(valid[3]), .tx_data(data3),
        .tx_ready(ready_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]),
        .fifo_level(lvl3), .uart_txd(txd_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int k, input logic [8:0] d, output int acc);
        int n;
        n = 0;
        case (k)
            0: data0 = d[7:0];
            1: data1 = d[7:0];
            2: data2 = d[7:0];
            default: data3 = d[6:0];
        endcase
        valid[k] = 1'b1;
        while (ready_w[k] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (ready_w[k] !== 1'b1) begin
            check("send_timeout", 32'(ready_w[k]), 1);
            valid[k] = 1'b0;
            return;
        end
        exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    // Decodes one frame from the line, sampling every cycle of every bit.
    task automatic rx_frame(input int k, input int dbits, input int pmode, input int sbits,
                            output int gap, output int t0);
        logic [12:0] bits;
        logic [8:0]  word;
        logic [8:0]  exp_w;
        logic        v, stable, busy_ok, stop_ok, exp_par;
        int          nbits, last, done_cnt, done_pos, idx;
        bits = '0;
        word = '0;
        stable = 1'b1;
        busy_ok = 1'b1;
        done_cnt = 0;
        done_pos = -1;
        gap = 0;
        @(negedge clk);
        while (txd_w[k] !== 1'b0 && gap < 3000) begin
            @(negedge clk);
            gap++;
        end
        t0 = cyc;
        if (txd_w[k] !== 1'b0) begin
            check("rx_timeout", 32'(txd_w[k]), 0);
            return;
        end
        nbits = 1 + dbits + ((pmode != 0) ? 1 : 0) + sbits;
        last = nbits * BPS - 1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < BPS; c++) begin
                idx = b * BPS + c;
                v = txd_w[k];
                if (c == 0) bits[b] = v;
                else if (v !== bits[b]) stable = 1'b0;
                if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
                if (done_w[k] === 1'b1) begin
                    done_cnt++;
                    done_pos = idx;
                end
                if (idx != last) @(negedge clk);
            end
        end
        for (int i = 0; i < dbits; i++) word[i] = bits[1 + i];
        stop_ok = 1'b1;
        for (int s = 0; s < sbits; s++) if (bits[nbits - 1 - s] !== 1'b1) stop_ok = 1'b0;
        check("rx_start", 32'(bits[0]), 0);
        check("rx_bit_width", 32'(stable), 1);
        check("rx_busy", 32'(busy_ok), 1);
        check("rx_stop", 32'(stop_ok), 1);
        check("rx_done_cnt", 32'(done_cnt), 1);
        check("rx_done_pos", 32'(done_pos), 32'(last));
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 1);
        end else begin
            exp_w = exp_q.pop_front();
            check("rx_data", 32'(word), 32'(exp_w));
            if (pmode != 0) begin
                exp_par = (pmode == 2) ? ^exp_w : ~^exp_w;
                check("rx_parity", 32'(bits[1 + dbits]), 32'(exp_par));
            end
        end
    endtask

    task automatic run_three(input int k, input int dbits, input int pmode, input int sbits,
                             input logic [8:0] first);
        int a, g, t;
        fork
            begin
                send(k, first, a);
                for (int i = 0; i < 2; i++) send(k, 9'($urandom_range(0, (1 << dbits) - 1)), a);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    rx_frame(k, dbits, pmode, sbits, g, t);
                    if (i > 0) check("b2b_gap", 32'(g), 0);
                end
            end
        join
        @(negedge clk);
        check("idle_busy", 32'(busy_w[k]), 0);
        check("idle_txd", 32'(txd_w[k]), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, gap, t0, low_cnt;
        int acc_a[6];
        int gap_a[6];
        rst = 1'b1;
        valid = '0;
        data0 = '0;
        data1 = '0;
        data2 = '0;
        data3 = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd_w), 15);
        check("rst_busy", 32'(busy_w), 0);
        check("rst_done", 32'(done_w), 0);
        check("rst_ready", 32'(ready_w), 15);
        check("rst_level", 32'({lvl3, lvl2, lvl1, lvl0}), 0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 single word: start bit one edge after acceptance, 100-cycle frame.
        fork
            send(0, 9'h055, acc);
            rx_frame(0, 8, 0, 1, gap, t0);
        join
        check("n1_latency", 32'(t0 - acc), 2);
        @(negedge clk);
        check("n1_busy_after", 32'(busy_w[0]), 0);
        check("n1_txd_after", 32'(txd_w[0]), 1);

        run_three(1, 8, 2, 1, 9'h007);
        run_three(2, 8, 1, 1, 9'h007);
        run_three(3, 7, 0, 2, 9'h07F);

        // Six consecutive valid cycles into a depth-4 FIFO.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(0, 9'($urandom_range(0, 255)), acc_a[i]);
                    if (i == 1) check("lvl_wr_pop", 32'(lvl0), 1);
                    if (i == 4) begin
                        check("lvl_full", 32'(lvl0), 4);
                        check("ready_full", 32'(ready_w[0]), 0);
                    end
                end
            end
            begin
                for (int i = 0; i < 6; i++) rx_frame(0, 8, 0, 1, gap_a[i], t0);
            end
        join
        check("accept6_delay", 32'(acc_a[5] - acc_a[0]), 102);
        for (int i = 1; i < 6; i++) check("burst_gap", 32'(gap_a[i]), 0);
        @(negedge clk);
        check("burst_idle", 32'(busy_w[0]), 0);

        // Reset in the middle of a frame with another word still queued.
        send(0, 9'h0F0, acc);
        send(0, 9'h099, acc);
        gap = 0;
        while (txd_w[0] !== 1'b0 && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        repeat (35) @(negedge clk);
        check("pre_rst_txd", 32'(txd_w[0]), 0);
        check("pre_rst_level", 32'(lvl0), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_txd", 32'(txd_w[0]), 1);
        check("mid_rst_busy", 32'(busy_w[0]), 0);
        check("mid_rst_level", 32'(lvl0), 0);
        check("mid_rst_ready", 32'(ready_w[0]), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fork
            send(0, 9'h0A3, acc);
            rx_frame(0, 8, 0, 1, gap, t0);
        join
        check("post_rst_latency", 32'(t0 - acc), 2);
        low_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) low_cnt++;
        end
        check("post_rst_quiet", 32'(low_cnt), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter. It replaces the fixed 8N1, edge-triggered sender with configurable data width, parity and stop bits. A valid/ready input handshake feeds an internal FIFO, so the producer (sensor/cipher datapath) can queue words and frames go out back-to-back without idle gaps. It sits between the data formatter and the board uart_txd pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
UART_BPS, 9600, line baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division, must be >= 2)
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 4, queue entries, power of two, >= 2

Ports:
sys_clk  in  1  system clock; the only clock
sys_rst  in  1  reset, asynchronous, active-high
tx_valid  in  1  producer has a word on tx_data
tx_data  in  DATA_BITS  word to send, LSB first on the line
tx_ready  out  1  FIFO can accept; equals !full
tx_busy  out  1  a frame is on the line (FSM not IDLE)
tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
uart_txd  out  1  serial line, registered, idle high

Behaviour:
- Reset (async assert, sync release): uart_txd=1, tx_busy=0, tx_done=0, fifo_level=0, tx_ready=1. FSM goes to IDLE and the FIFO empties. An in-flight frame is abandoned and the line goes high immediately.
- Accept: a word is written on the edge where tx_valid && tx_ready. tx_data is ignored otherwise. Write and pop may occur on the same edge when the FIFO is not full; fifo_level is then unchanged.
- Full: tx_ready=0 and the write is ignored, even if a pop happens on the same edge. tx_ready rises on the edge after the pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the FIFO is not empty, the FSM pops the head into a shift register and sets uart_txd=0 on that edge -> START. For a word accepted at edge E0 into an empty FIFO with the FSM in IDLE, the start bit begins at E1.
- Bit timing: every bit is held exactly BPS_CNT cycles. A baud counter runs 0..BPS_CNT-1 and advances state/bit index at BPS_CNT-1. Counter width is $clog2(BPS_CNT).
- START -> DATA. DATA sends DATA_BITS bits, LSB first. Then -> PARITY if PARITY_MODE!=0, else -> STOP.
- Parity bit: even = XOR of the data bits; odd = its inverse.
- STOP holds the line at 1 for STOP_BITS*BPS_CNT cycles.
- End of the last stop bit: tx_done pulses for 1 cycle. If the FIFO is not empty, the FSM pops the next word and drives the start bit on the same edge (zero idle gap). Otherwise -> IDLE.
- Frame length = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*BPS_CNT cycles.
- tx_busy=1 from the first start-bit cycle through the last stop-bit cycle.
- Illegal parameters: elaboration-time error via generate-time check. No runtime behaviour is defined for them.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), FSM state encoding, a function computing BPS_CNT and frame length.
- Sub-module sync_fifo: a single-clock FIFO parametrised by width and depth, with full/empty/level outputs. It is reused later by the UART receiver.

Test Plan:
Sim parameters unless noted: CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10).
- 8N1, write 0x55 at E0 -> uart_txd low from E1 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), then high 10 cycles. tx_done pulses once at E100. tx_busy high for 100 cycles.
- 8E1 with 0x07 -> parity bit 1. 8O1 with 0x07 -> parity bit 0. Frame is 110 cycles.
- DATA_BITS=7, STOP_BITS=2, PARITY_MODE=0, write 0x7F -> 7 ones then 20 high cycles. Frame is 100 cycles.
- FIFO_DEPTH=4, 6 consecutive tx_valid cycles -> first 5 accepted. tx_ready falls after the 5th accept (fifo_level=4). The 6th is accepted 1 cycle after the first frame's end pop. Frames follow with no idle gap.
- sys_rst asserted mid-DATA (cycle 35 of a frame) -> uart_txd=1, tx_busy=0, fifo_level=0 before the next edge. After release and a new write of 0xA3, a clean frame is sent.
